// File: rtl/ksa_pkg.sv
// Shared definitions for the 8b+12b Kogge-Stone adder datapath.
//   KSA_X_W   : width of operand X
//   KSA_Y_W   : width of operand Y
//   KSA_SUM_W : width of the sum, wider operand plus carry-out
//   ksa_sum_t : sum type as delivered by the adder core
package ksa_pkg;

  localparam int unsigned KSA_X_W   = 8;
  localparam int unsigned KSA_Y_W   = 12;
  localparam int unsigned KSA_SUM_W = 13;

  typedef logic [KSA_SUM_W-1:0] ksa_sum_t;

endpackage

// File: rtl/ksa_sum_skid_buffer.sv
// Registers the combinational Kogge-Stone sum into a small FIFO and presents it over
// valid/ready. This breaks the long prefix-tree path between the adder and its consumer.
// It also keeps a saturating count of accepted sums that carried out of the top bit.
//
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   in_valid     : adder sum valid this cycle
//   in_sum       : adder sum
//   in_ready     : buffer can accept in_sum this cycle (depends on registered level only)
//   out_valid    : head entry valid
//   out_sum      : head entry sum, 0 when empty
//   out_cout     : head entry carry-out (top bit of out_sum)
//   out_ready    : consumer accepts head this cycle
//   level        : occupancy, 0..DEPTH
//   cnt_clr      : synchronous clear of cout_cnt, wins over a counting push
//   cout_cnt     : saturating count of accepted sums with carry-out set
//
// DEPTH must be a power of two and at least 2 so that the pointers wrap naturally.
module ksa_sum_skid_buffer
  import ksa_pkg::*;
#(
  parameter int unsigned SUM_W = KSA_SUM_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SUM_W-1:0]       in_sum,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [SUM_W-1:0]       out_sum,
  output logic                   out_cout,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cout_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LevelFull = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LevelOne  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [SUM_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;

  // Handshake flags come from registered state only, so there is no combinational
  // path from out_ready to in_ready.
  assign in_ready  = (level_q != LevelFull);
  assign out_valid = (level_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Head is read straight from storage; masked to 0 when empty so stale contents
  // never leak onto the output.
  always_comb begin
    out_sum = '0;
    if (out_valid) begin
      out_sum = mem_q[rd_ptr_q];
    end
  end

  assign out_cout = out_sum[SUM_W-1];
  assign level    = level_q;
  assign cout_cnt = cnt_q;

  // Pointer and occupancy next-state. Pointers wrap modulo DEPTH by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  // Carry-out counter: clear wins, otherwise count accepted carry-outs and stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (push && in_sum[SUM_W-1] && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked by out_valid and writes only happen on push,
  // so whatever sits on in_sum while not pushing is never captured.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_sum;
    end
  end

endmodule

// File: tb/tb_ksa_sum_skid_buffer.sv
// Randomized self-checking bench for ksa_sum_skid_buffer. A queue-based reference model
// tracks expected FIFO contents and carry-out counts. A second instance with a 3-bit
// counter reaches saturation in a few cycles.
module tb_ksa_sum_skid_buffer;
  import ksa_pkg::*;

  localparam int unsigned SUM_W  = KSA_SUM_W;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNTS_W = 3;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam int          CNTS_MAX = (1 << CNTS_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic             in_ready;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic             out_cout;
  logic             out_ready;
  logic [1:0]       level;
  logic             cnt_clr;
  logic [CNT_W-1:0] cout_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [SUM_W-1:0]  s_out_sum;
  logic              s_out_cout;
  logic [1:0]        s_level;
  logic [CNTS_W-1:0] s_cout_cnt;

  ksa_sum_skid_buffer #(
    .SUM_W(SUM_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ready(out_ready),
    .level    (level),
    .cnt_clr  (cnt_clr),
    .cout_cnt (cout_cnt)
  );

  ksa_sum_skid_buffer #(
    .SUM_W(SUM_W),
    .DEPTH(DEPTH),
    .CNT_W(CNTS_W)
  ) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_ready (s_in_ready),
    .out_valid(s_out_valid),
    .out_sum  (s_out_sum),
    .out_cout (s_out_cout),
    .out_ready(out_ready),
    .level    (s_level),
    .cnt_clr  (cnt_clr),
    .cout_cnt (s_cout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [SUM_W-1:0] model_q[$];
  int               cnt_m;
  int               cnts_m;
  int               n_chk;
  int               n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [SUM_W-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, ".level"},     32'(level),      32'(model_q.size()));
    check({tag, ".out_valid"}, 32'(out_valid),  32'(model_q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),   32'(model_q.size() < DEPTH));
    check({tag, ".out_sum"},   32'(out_sum),    32'(head));
    check({tag, ".out_cout"},  32'(out_cout),   32'(head[SUM_W-1]));
    check({tag, ".cout_cnt"},  32'(cout_cnt),   32'(cnt_m));
    check({tag, ".sat_cnt"},   32'(s_cout_cnt), 32'(cnts_m));
    check({tag, ".sat_sum"},   32'(s_out_sum),  32'(head));
  endtask

  // One clock: predict from the current model and inputs, advance, compare #1 after edge.
  task automatic step(input string tag);
    bit               push;
    bit               pop;
    logic [SUM_W-1:0] sum;
    push = (in_valid === 1'b1) && (model_q.size() < DEPTH);
    pop  = (model_q.size() > 0) && (out_ready === 1'b1);
    sum  = in_sum;
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back(sum);
    if (cnt_clr) begin
      cnt_m  = 0;
      cnts_m = 0;
    end else if (push && sum[SUM_W-1]) begin
      cnt_m  = (cnt_m + 1 > CNT_MAX) ? CNT_MAX : cnt_m + 1;
      cnts_m = (cnts_m + 1 > CNTS_MAX) ? CNTS_MAX : cnts_m + 1;
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [SUM_W-1:0] add_xy(input int x, input int y);
    return SUM_W'(x + y);
  endfunction

  function automatic logic [SUM_W-1:0] rand_sum();
    return add_xy(int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)));
  endfunction

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    cnt_m     = 0;
    cnts_m    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset values
    #3;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.level",     32'(level),     32'd0);
    check("rst.cout_cnt",  32'(cout_cnt),  32'd0);
    check("rst.out_sum",   32'(out_sum),   32'd0);
    #4;
    rst_n = 1'b1;

    // Single push of 8'hFF + 12'hFFF
    in_valid = 1'b1;
    in_sum   = add_xy(8'hFF, 12'hFFF);
    step("single");
    check("single.sum", 32'(out_sum), 32'h10FE);
    check("single.cout", 32'(out_cout), 32'd1);
    check("single.cnt", 32'(cout_cnt), 32'd1);
    in_valid = 1'b0;
    in_sum   = 'x;
    out_ready = 1'b1;
    step("single_drain");

    // Fill and backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 13'h0001;
    step("fill1");
    in_sum = 13'h0002;
    step("fill2");
    check("fill.level", 32'(level), 32'd2);
    check("fill.in_ready", 32'(in_ready), 32'd0);
    in_sum = 13'h0003;
    step("fill_blocked");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("drain.first", 32'(out_sum), 32'h0001);
    step("drain1");
    check("drain.in_ready", 32'(in_ready), 32'd1);
    check("drain.second", 32'(out_sum), 32'h0002);
    step("drain2");

    // Streaming
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_sum = rand_sum();
      step("stream");
      check("stream.level1", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    step("stream_tail");

    // Random valid/ready traffic, junk on in_sum while idle
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = in_valid ? rand_sum() : SUM_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      step("random");
    end
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("random_tail");
    step("random_tail");

    // Counter saturation: clear, then carry-out pushes until the small counter saturates
    cnt_clr = 1'b1;
    step("cnt_clear");
    cnt_clr  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < CNTS_MAX - 1; i++) begin
      in_sum = 13'h1000 | SUM_W'(i);
      step("cnt_preload");
    end
    check("cnt.preload", 32'(s_cout_cnt), 32'(CNTS_MAX - 1));
    for (int i = 0; i < 3; i++) begin
      in_sum = 13'h1F00 | SUM_W'(i);
      step("cnt_sat");
    end
    check("cnt.saturated", 32'(s_cout_cnt), 32'(CNTS_MAX));
    check("cnt.main", 32'(cout_cnt), 32'(CNTS_MAX + 2));
    cnt_clr = 1'b1;
    in_sum  = 13'h1000;
    step("cnt_clr_push");
    check("cnt.clr_main", 32'(cout_cnt), 32'd0);
    check("cnt.clr_sat", 32'(s_cout_cnt), 32'd0);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    step("cnt_tail");
    step("cnt_tail");

    // Async reset mid-cycle with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 13'h0111;
    step("pre_rst1");
    in_sum = 13'h0222;
    step("pre_rst2");
    check("pre_rst.level", 32'(level), 32'd2);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.level", 32'(level), 32'd0);
    check("mid_rst.cnt", 32'(cout_cnt), 32'd0);
    model_q.delete();
    cnt_m  = 0;
    cnts_m = 0;
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 13'h0ABC;
    step("post_rst");
    check("post_rst.first", 32'(out_sum), 32'h0ABC);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
